wm_block_scheduler: RTL and testbench

//  Sequences the watermarking datapath over the image in MxM blocks. After a start

---
 rtl/wm_pkg.sv | 29 ++
 rtl/wm_block_counter.sv | 45 ++++
 rtl/wm_block_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_wm_block_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// Shared definitions for the watermarking block: register map, scheduler
// states and default datapath widths.
package wm_pkg;

  localparam int AMBA_ADDR_DEPTH = 20;
  localparam int DIM_WIDTH       = 10;
  localparam int BLOCK_DEPTH     = 7;
  localparam int DATA_DEPTH      = 8;

  localparam int ADDR_CTRL     = 0;
  localparam int ADDR_IWHITE   = 1;
  localparam int ADDR_NP       = 2;
  localparam int ADDR_NW       = 3;
  localparam int ADDR_M        = 4;
  localparam int ADDR_BTHR     = 5;
  localparam int ADDR_BMAX     = 9;
  localparam int ADDR_PIX_BASE = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_STAT,
    S_WAIT_STAT,
    S_MARK,
    S_DONE,
    S_ERR
  } sched_state_e;

endpackage

// File: rtl/wm_block_counter.sv
// Row/column position inside the current MxM block, advanced once per
// accepted address pair; wraps to (0,0) after the last pixel of the block.
module wm_block_counter
  import wm_pkg::*;
#(
  parameter int Block_Depth = BLOCK_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic                   i_adv,
  input  logic [Block_Depth-1:0] i_m,
  output logic                   o_first,
  output logic                   o_last,
  output logic                   o_row_end
);

  logic [Block_Depth-1:0] r_row;
  logic [Block_Depth-1:0] r_col;
  logic [Block_Depth-1:0] w_m_max;
  logic                   w_row_last;

  assign w_m_max    = i_m - Block_Depth'(1);
  assign w_row_last = (r_row == w_m_max);
  assign o_row_end  = (r_col == w_m_max);
  assign o_first    = (r_row == '0) && (r_col == '0);
  assign o_last     = w_row_last && o_row_end;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order of statements in the block.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_adv) begin
      if (o_row_end) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + Block_Depth'(1);
      end else begin
        r_col <= r_col + Block_Depth'(1);
      end
    end
  end

endmodule

// File: rtl/wm_block_scheduler.sv
// Walks the image block by block, issuing primary/watermark address pairs
// for a STAT pass and then a MARK pass over every MxM block.
module wm_block_scheduler
  import wm_pkg::*;
#(
  parameter int Amba_Addr_Depth = AMBA_ADDR_DEPTH,
  parameter int Dim_Width       = DIM_WIDTH,
  parameter int Block_Depth     = BLOCK_DEPTH,
  parameter int Data_Depth      = DATA_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [Dim_Width-1:0]       cfg_np,
  input  logic [Dim_Width-1:0]       cfg_nw,
  input  logic [Data_Depth-1:0]      cfg_m,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [Amba_Addr_Depth-1:0] rd_addr_p,
  output logic [Amba_Addr_Depth-1:0] rd_addr_w,
  output logic                       pass_mark,
  output logic                       blk_first,
  output logic                       blk_last,
  input  logic                       stats_done,
  output logic                       busy,
  output logic                       cfg_err,
  output logic                       image_done
);

  sched_state_e               r_state;
  logic [Dim_Width-1:0]       r_np;
  logic [Dim_Width-1:0]       r_nw;
  logic [Data_Depth-1:0]      r_m;
  logic [Dim_Width-1:0]       r_rem;
  logic [Dim_Width-1:0]       r_blk_c;
  logic [Dim_Width-1:0]       r_blk_r;
  logic [Amba_Addr_Depth-1:0] r_npnp;
  logic [Amba_Addr_Depth-1:0] r_addr_p;
  logic [Amba_Addr_Depth-1:0] r_row_p;
  logic [Amba_Addr_Depth-1:0] r_blk_p;
  logic                       r_valid;
  logic                       r_pass_mark;
  logic                       r_busy;
  logic                       r_cfg_err;
  logic                       r_done;

  logic [2*Dim_Width-1:0]     w_npnp;
  logic [Dim_Width-1:0]       w_m_ext;
  logic [Amba_Addr_Depth-1:0] w_m_addr;
  logic [Amba_Addr_Depth-1:0] w_np_addr;
  logic [Amba_Addr_Depth-1:0] w_addr_step;
  logic                       w_cfg_bad;
  logic                       w_accept;
  logic                       w_first;
  logic                       w_last;
  logic                       w_row_end;
  logic                       w_blk_c_last;
  logic                       w_blk_r_last;

  assign w_npnp    = {{Dim_Width{1'b0}}, r_np} * {{Dim_Width{1'b0}}, r_np};
  assign w_m_ext   = Dim_Width'(r_m);
  assign w_m_addr  = Amba_Addr_Depth'(r_m);
  assign w_np_addr = Amba_Addr_Depth'(r_np);
  assign w_cfg_bad = (r_m == '0) || (r_np == '0) || (w_m_ext > r_np) || (r_nw != r_np);
  assign w_accept  = r_valid && rd_ready;

  assign w_blk_c_last = (r_blk_c + w_m_ext) == r_np;
  assign w_blk_r_last = (r_blk_r + w_m_ext) == r_np;

  // Next pixel inside the block: one column right, or down one image row.
  assign w_addr_step = w_row_end ? (r_row_p + w_np_addr) : (r_addr_p + Amba_Addr_Depth'(1));

  wm_block_counter #(
    .Block_Depth (Block_Depth)
  ) u_blk_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state == S_CHECK),
    .i_adv     (w_accept),
    .i_m       (Block_Depth'(r_m)),
    .o_first   (w_first),
    .o_last    (w_last),
    .o_row_end (w_row_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_np        <= '0;
      r_nw        <= '0;
      r_m         <= '0;
      r_rem       <= '0;
      r_blk_c     <= '0;
      r_blk_r     <= '0;
      r_npnp      <= '0;
      r_addr_p    <= '0;
      r_row_p     <= '0;
      r_blk_p     <= '0;
      r_valid     <= 1'b0;
      r_pass_mark <= 1'b0;
      r_busy      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_np      <= cfg_np;
            r_nw      <= cfg_nw;
            r_m       <= cfg_m;
            r_rem     <= cfg_np;
            r_cfg_err <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_npnp   <= Amba_Addr_Depth'(w_npnp);
          r_addr_p <= Amba_Addr_Depth'(ADDR_PIX_BASE);
          r_row_p  <= Amba_Addr_Depth'(ADDR_PIX_BASE);
          r_blk_p  <= Amba_Addr_Depth'(ADDR_PIX_BASE);
          r_blk_c  <= '0;
          r_blk_r  <= '0;
          // Divisibility by repeated subtraction: Np must be a multiple of M.
          if (w_cfg_bad || ((r_rem < w_m_ext) && (r_rem != '0))) begin
            r_state   <= S_ERR;
            r_cfg_err <= 1'b1;
            r_busy    <= 1'b0;
          end else if (r_rem < w_m_ext) begin
            r_state     <= S_STAT;
            r_valid     <= 1'b1;
            r_pass_mark <= 1'b0;
          end else begin
            r_rem <= r_rem - w_m_ext;
          end
        end
        S_ERR: r_state <= S_IDLE;
        S_STAT: begin
          if (w_accept) begin
            if (w_last) begin
              r_valid  <= 1'b0;
              r_state  <= S_WAIT_STAT;
              r_addr_p <= r_blk_p;
              r_row_p  <= r_blk_p;
            end else begin
              r_addr_p <= w_addr_step;
              if (w_row_end) r_row_p <= w_addr_step;
            end
          end
        end
        S_WAIT_STAT: begin
          if (stats_done) begin
            r_state     <= S_MARK;
            r_valid     <= 1'b1;
            r_pass_mark <= 1'b1;
          end
        end
        S_MARK: begin
          if (w_accept) begin
            if (w_last) begin
              r_pass_mark <= 1'b0;
              if (w_blk_c_last && w_blk_r_last) begin
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else if (w_blk_c_last) begin
                // The pixel after the last one of a block row starts the next block row.
                r_blk_c  <= '0;
                r_blk_r  <= r_blk_r + w_m_ext;
                r_addr_p <= r_addr_p + Amba_Addr_Depth'(1);
                r_row_p  <= r_addr_p + Amba_Addr_Depth'(1);
                r_blk_p  <= r_addr_p + Amba_Addr_Depth'(1);
                r_state  <= S_STAT;
              end else begin
                r_blk_c  <= r_blk_c + w_m_ext;
                r_addr_p <= r_blk_p + w_m_addr;
                r_row_p  <= r_blk_p + w_m_addr;
                r_blk_p  <= r_blk_p + w_m_addr;
                r_state  <= S_STAT;
              end
            end else begin
              r_addr_p <= w_addr_step;
              if (w_row_end) r_row_p <= w_addr_step;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_valid   = r_valid;
  assign rd_addr_p  = r_addr_p;
  assign rd_addr_w  = r_addr_p + r_npnp;
  assign pass_mark  = r_pass_mark;
  assign blk_first  = r_valid && w_first;
  assign blk_last   = r_valid && w_last;
  assign busy       = r_busy;
  assign cfg_err    = r_cfg_err;
  assign image_done = r_done;

endmodule

// File: tb/tb_wm_block_scheduler.sv
// Directed bench for wm_block_scheduler: raster walk, stalls, config errors,
// ignored start/stats_done pulses and mid-run reset.
module tb_wm_block_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  cfg_np = '0;
  logic [9:0]  cfg_nw = '0;
  logic [7:0]  cfg_m = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [19:0] rd_addr_p;
  logic [19:0] rd_addr_w;
  logic        pass_mark;
  logic        blk_first;
  logic        blk_last;
  logic        stats_done = 1'b0;
  logic        busy;
  logic        cfg_err;
  logic        image_done;

  int n_checks = 0;
  int n_pass   = 0;
  int q_p[$];
  int q_w[$];
  logic q_f[$];
  logic q_l[$];

  always #5 clk = ~clk;

  wm_block_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_np     (cfg_np),
    .cfg_nw     (cfg_nw),
    .cfg_m      (cfg_m),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_addr_p  (rd_addr_p),
    .rd_addr_w  (rd_addr_w),
    .pass_mark  (pass_mark),
    .blk_first  (blk_first),
    .blk_last   (blk_last),
    .stats_done (stats_done),
    .busy       (busy),
    .cfg_err    (cfg_err),
    .image_done (image_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rd_valid"}, rd_valid, 0);
    check({tag, " rd_addr_p"}, rd_addr_p, 0);
    check({tag, " rd_addr_w"}, rd_addr_w, 0);
    check({tag, " pass_mark"}, pass_mark, 0);
    check({tag, " blk_first"}, blk_first, 0);
    check({tag, " blk_last"}, blk_last, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " cfg_err"}, cfg_err, 0);
    check({tag, " image_done"}, image_done, 0);
  endtask

  task automatic do_start(input int np, input int nw, input int m);
    cfg_np = 10'(np);
    cfg_nw = 10'(nw);
    cfg_m  = 8'(m);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Wait (bounded) for the handshake, then compare the accepted pair.
  task automatic expect_pair(input string tag, input int ep, input int ew, input logic pm,
                             input logic f, input logic l, input int pct, input bit now);
    int guard;
    guard = 0;
    rd_ready = ($urandom_range(0, 99) < pct);
    while (!(rd_valid === 1'b1 && rd_ready) && guard < 200) begin
      if (rd_valid === 1'b1) check({tag, " stalled addr_p"}, rd_addr_p, ep);
      @(negedge clk);
      guard++;
      rd_ready = ($urandom_range(0, 99) < pct);
    end
    check({tag, " handshake in time"}, guard < 200, 1);
    if (now) check({tag, " no bubble"}, guard, 0);
    check({tag, " addr_p"}, rd_addr_p, ep);
    check({tag, " addr_w"}, rd_addr_w, ew);
    check({tag, " pass_mark"}, pass_mark, pm);
    check({tag, " blk_first"}, blk_first, f);
    check({tag, " blk_last"}, blk_last, l);
    q_p.push_back(int'(rd_addr_p));
    q_w.push_back(int'(rd_addr_w));
    q_f.push_back(blk_first);
    q_l.push_back(blk_last);
    @(negedge clk);
  endtask

  task automatic pulse_stats(input string tag);
    for (int k = 0; k < 3; k++) begin
      check({tag, " wait_stat rd_valid"}, rd_valid, 0);
      @(negedge clk);
    end
    stats_done = 1'b1;
    @(negedge clk);
    stats_done = 1'b0;
  endtask

  task automatic run_image(input string tag, input int np, input int m, input int pct,
                           input bit early_stats);
    int nb, ep;
    bit first, last, now;
    nb = np / m;
    q_p.delete(); q_w.delete(); q_f.delete(); q_l.delete();
    do_start(np, np, m);
    check({tag, " busy after start"}, busy, 1);
    check({tag, " cfg_err after start"}, cfg_err, 0);
    check({tag, " image_done after start"}, image_done, 0);
    for (int br = 0; br < nb; br++)
      for (int bc = 0; bc < nb; bc++)
        for (int pass = 0; pass < 2; pass++) begin
          for (int r = 0; r < m; r++)
            for (int c = 0; c < m; c++) begin
              ep    = 10 + (br * m + r) * np + bc * m + c;
              first = (r == 0) && (c == 0);
              last  = (r == m - 1) && (c == m - 1);
              now   = (pct == 100) && !(pass == 0 && br == 0 && bc == 0 && first);
              stats_done = early_stats && pass == 0 && br == 0 && bc == 0 && r == 0 && c == 1;
              expect_pair(tag, ep, ep + np * np, pass == 1, first, last, pct, now);
              stats_done = 1'b0;
            end
          if (pass == 0) pulse_stats(tag);
        end
    check({tag, " image_done"}, image_done, 1);
    check({tag, " busy at done"}, busy, 0);
    check({tag, " rd_valid at done"}, rd_valid, 0);
    check({tag, " accept count"}, q_p.size(), 2 * np * np);
  endtask

  task automatic run_err(input string tag, input int np, input int nw, input int m);
    int guard;
    bit seen_valid;
    guard = 0;
    seen_valid = 0;
    do_start(np, nw, m);
    while (busy === 1'b1 && guard < 40) begin
      if (rd_valid === 1'b1) seen_valid = 1;
      @(negedge clk);
      guard++;
    end
    check({tag, " busy dropped in time"}, guard < 40, 1);
    check({tag, " cfg_err"}, cfg_err, 1);
    check({tag, " busy"}, busy, 0);
    check({tag, " rd_valid never seen"}, seen_valid, 0);
    repeat (3) @(negedge clk);
    check({tag, " cfg_err sticky"}, cfg_err, 1);
    check({tag, " rd_valid idle"}, rd_valid, 0);
    check({tag, " image_done"}, image_done, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int idx_t[10];
    int exp_t[10];
    idx_t = '{0, 1, 2, 3, 4, 8, 9, 10, 11, 31};
    exp_t = '{10, 11, 14, 15, 10, 12, 13, 16, 17, 25};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    // 4x4 image, 2x2 blocks, always ready, early stats_done must be ignored.
    run_image("t1", 4, 2, 100, 1'b1);
    for (int i = 0; i < 10; i++) check("t1 table addr_p", q_p[idx_t[i]], exp_t[i]);
    check("t1 w[0]", q_w[0], 26);
    check("t1 w[1]", q_w[1], 27);
    check("t1 w[2]", q_w[2], 30);
    check("t1 w[3]", q_w[3], 31);
    check("t1 w[31]", q_w[31], 41);

    // Same image with random back-pressure.
    run_image("t2", 4, 2, 50, 1'b0);
    check("t2 last addr_p", q_p[31], 25);

    // Configuration errors: non-divisible, Nw!=Np, M==0, M>Np.
    run_err("e1", 6, 6, 4);
    run_err("e2", 4, 8, 2);
    run_err("e3", 4, 4, 0);
    run_err("e4", 2, 2, 4);

    // Single-block image; the start also clears the sticky cfg_err.
    run_image("t4", 4, 4, 100, 1'b0);
    check("t4 first addr", q_p[0], 10);
    check("t4 first flag", q_f[0], 1);
    check("t4 last addr", q_p[15], 25);
    check("t4 last flag", q_l[15], 1);

    // start mid-MARK is ignored; reset mid-MARK clears everything.
    q_p.delete(); q_w.delete(); q_f.delete(); q_l.delete();
    do_start(4, 4, 2);
    expect_pair("t5 s0", 10, 26, 0, 1, 0, 100, 0);
    expect_pair("t5 s1", 11, 27, 0, 0, 0, 100, 1);
    expect_pair("t5 s2", 14, 30, 0, 0, 0, 100, 1);
    expect_pair("t5 s3", 15, 31, 0, 0, 1, 100, 1);
    pulse_stats("t5");
    cfg_np = 10'd8;
    cfg_nw = 10'd8;
    start  = 1'b1;
    expect_pair("t5 m0", 10, 26, 1, 1, 0, 100, 1);
    start  = 1'b0;
    expect_pair("t5 m1", 11, 27, 1, 0, 0, 100, 1);
    check("t5 busy mid-mark", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("t5 rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t5 idle after rst", rd_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
